fir_audio_filter: RTL and testbench

//   16-tap direct-form low-pass FIR that cleans a noisy 16-bit PCM audio stream.

---
 rtl/fir_audio_filter.sv | 89 ++++++++
 tb/tb_fir_audio_filter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_audio_filter.sv
// ---------------------------------------------------------------------------
// fir_audio_filter
//
// Purpose:
//   16-tap direct-form low-pass FIR for a 16-bit signed PCM audio stream.
//   One sample enters and one filtered sample leaves on every clock. There is
//   no handshake. The coefficients are fixed, symmetric Q1.15 values whose
//   sum is exactly 32768, so the DC gain is exactly 1.0.
//
// Ports:
//   Clk   in   1   system clock, all state updates on the rising edge
//   Rst   in   1   synchronous active-high reset (clears history and output)
//   Xin   in   16  signed input sample, captured on every rising edge
//   Yout  out  16  signed filtered sample, registered
//
// Timing:
//   The sample captured at edge n sits in x[0] after that edge. The output
//   register loads the filter of the current delay-line contents, so that
//   sample first affects Yout after edge n+1. This is a one-cycle pipeline.
// ---------------------------------------------------------------------------
module fir_audio_filter (
    input  logic               Clk,
    input  logic               Rst,
    input  logic signed [15:0] Xin,
    output logic signed [15:0] Yout
);

    localparam int NTAPS = 16;
    localparam int ACC_W = 36;

    // Low-pass taps h0..h15 in Q1.15. They are symmetric and sum to 32768.
    localparam logic signed [15:0] COEFFS [NTAPS] = '{
        -16'sd256,  -16'sd512,  16'sd0,     16'sd1024,
        16'sd2304,  16'sd3584,  16'sd4608,  16'sd5632,
        16'sd5632,  16'sd4608,  16'sd3584,  16'sd2304,
        16'sd1024,  16'sd0,     -16'sd512,  -16'sd256
    };

    localparam logic signed [ACC_W-1:0] ROUND_HALF = 36'sd16384;
    localparam logic signed [ACC_W-1:0] SAT_MAX    = 36'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN    = -36'sd32768;

    // x[0] holds the newest captured sample and x[15] the oldest.
    logic signed [15:0]      x [NTAPS];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rounded;
    logic signed [15:0]      y_next;

    // Exact multiply-accumulate over the whole delay line.
    // The worst-case magnitude is about 35840 * 32768, which fits easily in
    // 36 bits. Each product is formed at full accumulator width, so nothing
    // wraps before the sum is taken.
    // The rounding step adds half an LSB and then shifts arithmetically.
    // This rounds half toward +infinity, including for negative sums.
    // The result saturates so that a large overshoot never wraps its sign.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + (36'(COEFFS[k]) * 36'(x[k]));
        end
        rounded = (acc + ROUND_HALF) >>> 15;
        if (rounded > SAT_MAX) begin
            y_next = 16'sh7fff;
        end else if (rounded < SAT_MIN) begin
            y_next = -16'sh8000;
        end else begin
            y_next = rounded[15:0];
        end
    end

    // Delay line shift and output register.
    // Reset takes priority over capturing a sample, so after a reset the
    // filter restarts from an all-zero history.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                x[k] <= '0;
            end
            Yout <= '0;
        end else begin
            x[0] <= Xin;
            for (int k = 1; k < NTAPS; k++) begin
                x[k] <= x[k-1];
            end
            Yout <= y_next;
        end
    end

endmodule

// File: tb/tb_fir_audio_filter.sv
// ---------------------------------------------------------------------------
// tb_fir_audio_filter
//
// Self-checking bench for fir_audio_filter.
//   - Table of reset and impulse vectors with literal expected outputs.
//   - Hand-written sequences: DC settling, positive and negative saturation,
//     and a reset in the middle of a stream.
//   - A randomized stream compared against a reference model. The model
//     keeps the recent input history in a queue and evaluates the filter
//     equation with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_fir_audio_filter;

    logic               Clk;
    logic               Rst;
    logic signed [15:0] Xin;
    logic signed [15:0] Yout;

    int testsRun  = 0;
    int testsFail = 0;

    // Filter taps as plain integers, newest-sample tap first.
    int H [16] = '{-256, -512, 0, 1024, 2304, 3584, 4608, 5632,
                   5632, 4608, 3584, 2304, 1024, 0, -512, -256};

    // Model history: hist[0] is the newest captured sample.
    int hist [$];
    logic signed [15:0] modelY;

    typedef struct {
        logic               rst;
        logic signed [15:0] xin;
        logic signed [15:0] expected;
        string              name;
    } vector_t;

    vector_t vecs [$];

    fir_audio_filter dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Xin  (Xin),
        .Yout (Yout)
    );

    // 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: y = sat(floor((sum h*x + 2^14) / 2^15)).
    function automatic logic signed [15:0] modelOut();
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            acc += longint'(H[k]) * longint'(hist[k]);
        end
        r = (acc + 64'sd16384) >>> 15;
        if (r > 32767) begin
            return 16'sh7fff;
        end
        if (r < -32768) begin
            return -16'sh8000;
        end
        return 16'(r);
    endfunction

    function automatic void clearHistory();
        hist.delete();
        for (int k = 0; k < 16; k++) begin
            hist.push_back(0);
        end
    endfunction

    // Drive one sample and one reset value, then wait for the clock edge.
    // After the edge the DUT's Yout reflects the history held before this
    // edge. The model therefore computes its output first and shifts the
    // new sample in afterwards. Control returns 1 ns after the edge, which
    // is when outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic signed [15:0] x);
        Rst = rst;
        Xin = x;
        @(posedge Clk);
        if (rst) begin
            modelY = '0;
            clearHistory();
        end else begin
            modelY = modelOut();
            hist.push_front(int'(x));
            void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic signed [15:0] expected);
        testsRun++;
        if (Yout !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: Yout=%0d expected=%0d", name, Yout, expected);
        end
    endtask

    // Load the delay line so that tap k holds pat[k], then clock once more
    // so that the output register reflects that history.
    task automatic loadPattern(input logic signed [15:0] pat [16]);
        for (int k = 15; k >= 0; k--) begin
            applyStimulus(1'b0, pat[k]);
        end
        applyStimulus(1'b0, 16'sd0);
    endtask

    initial begin
        logic signed [15:0] impulse [16];
        logic signed [15:0] pat [16];
        logic signed [15:0] rx;
        logic               rrst;

        impulse = '{-16'sd256, -16'sd512, 16'sd0, 16'sd1024, 16'sd2304, 16'sd3584,
                    16'sd4608, 16'sd5632, 16'sd5632, 16'sd4608, 16'sd3584, 16'sd2304,
                    16'sd1024, 16'sd0, -16'sd512, -16'sd256};

        Rst = 1'b1;
        Xin = '0;
        clearHistory();

        // ---------------- table-driven reset and impulse vectors ----------
        vecs.push_back('{1'b1, 16'sd12345, 16'sd0,   "reset_hold0"});
        vecs.push_back('{1'b1, 16'sd12345, 16'sd0,   "reset_hold1"});
        vecs.push_back('{1'b0, 16'sd12345, 16'sd0,   "reset_release"});
        vecs.push_back('{1'b0, 16'sd0,     -16'sd96, "reset_first_out"});
        vecs.push_back('{1'b1, 16'sd0,     16'sd0,   "impulse_clear"});
        vecs.push_back('{1'b0, 16'sd32767, 16'sd0,   "impulse_capture"});
        for (int k = 0; k < 16; k++) begin
            vecs.push_back('{1'b0, 16'sd0, impulse[k], $sformatf("impulse_tap%0d", k)});
        end
        vecs.push_back('{1'b0, 16'sd0, 16'sd0, "impulse_tail"});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].xin);
            checkOutput(vecs[i].name, vecs[i].expected);
        end

        // ---------------- DC settling, positive and negative ---------------
        applyStimulus(1'b1, 16'sd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 16'sd1000);
            if (i >= 16) begin
                checkOutput("dc_pos", 16'sd1000);
            end
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, -16'sd1000);
            if (i >= 16) begin
                checkOutput("dc_neg", -16'sd1000);
            end
        end

        // ---------------- saturation ----------------------------------------
        // Negative taps (0, 1, 14, 15) are driven to -32768 and all other
        // taps to +32767. The resulting sum overshoots full scale.
        for (int k = 0; k < 16; k++) begin
            pat[k] = (k < 2 || k > 13) ? -16'sh8000 : 16'sh7fff;
        end
        loadPattern(pat);
        checkOutput("sat_pos", 16'sh7fff);
        for (int k = 0; k < 16; k++) begin
            pat[k] = (k < 2 || k > 13) ? 16'sh7fff : -16'sh8000;
        end
        loadPattern(pat);
        checkOutput("sat_neg", -16'sh8000);

        // ---------------- mid-stream reset ----------------------------------
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 16'(i * 1500 - 8000));
            checkOutput("ramp_model", modelY);
        end
        applyStimulus(1'b1, 16'sd7777);
        checkOutput("midreset_zero", 16'sd0);
        applyStimulus(1'b0, 16'sd32767);
        checkOutput("midreset_capture", 16'sd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 16'sd0);
            checkOutput($sformatf("midreset_tap%0d", k), impulse[k]);
        end

        // ---------------- randomized stream vs model ------------------------
        applyStimulus(1'b1, 16'sd0);
        for (int i = 0; i < 400; i++) begin
            rrst = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 3))
                0:       rx = ($urandom_range(0, 1) != 0) ? 16'sh7fff : -16'sh8000;
                default: rx = 16'($urandom);
            endcase
            applyStimulus(rrst, rx);
            checkOutput("random_model", modelY);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
